logic_seq_player: RTL and testbench
===================================

# logic_seq_player

Sequence player sitting directly downstream of the logic start-address selector. On a start strobe it latches the selected 8-bit start address and walks a writable 256-entry step table: it drives each entry's 8-bit output pattern for a programmed number of cycles, advances to the next entry, and stops at an entry flagged "last". Step-table writes use the same address/write-enable/data style as the start-address register file, so firmware can reprogram sequences at run time.

## Interface
- IDLE_PATTERN, 8'h00, value driven on seq_out after reset and after abort
- MAX_STEPS, 256, step limit per run before forced termination with err

- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle run request; sampled only in IDLE
- logic_start_addr  in  8  first table index of the run; latched when start is accepted
- abort  in  1  terminate any run; has priority over start
- s_addr  in  8  step-table write index
- s_wren  in  1  step-table write enable
- s_data  in  16  entry: [15]=last, [14:8]=hold (0..127), [7:0]=pattern
- seq_out  out  8  registered output pattern
- cur_addr  out  8  table index of the step currently fetched or held
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse on normal or err completion
- err  out  1  sticky: run hit MAX_STEPS without a last entry; cleared by the next accepted start

## Operation
- Table: 256x16, synchronous write (mem[s_addr] <= s_data when s_wren), synchronous read (1-cycle latency). Not reset; contents undefined until written. Writes are accepted in any state.
- Read/write to the same index on the same edge: the read returns old data. A write to a not-yet-fetched index during a run affects that run.
- States: IDLE, FETCH, APPLY, HOLD, FINISH.
- IDLE:
  - On start && !abort: ptr <= logic_start_addr, step_cnt <= 0, err <= 0 -> FETCH.
  - start while not IDLE is ignored (no queuing).
- FETCH: issue read of mem[ptr]; cur_addr <= ptr -> APPLY.
- APPLY: read data valid. seq_out <= pattern, hold_cnt <= hold, last_r <= last, step_cnt <= step_cnt+1 -> HOLD.
- HOLD:
  - If hold_cnt != 0: hold_cnt <= hold_cnt-1.
  - Otherwise:
    - last_r -> FINISH.
    - Else step_cnt == MAX_STEPS -> err <= 1 -> FINISH.
    - Else ptr <= ptr+1 (8-bit wrap, 255 -> 0) -> FETCH.
- FINISH: done high for this single cycle -> IDLE. seq_out keeps the last pattern until the next run's first APPLY.
- abort in any non-IDLE state: next edge -> IDLE, seq_out <= IDLE_PATTERN, done stays low, err unchanged. abort in IDLE: seq_out <= IDLE_PATTERN.
- Reset values: seq_out=IDLE_PATTERN, cur_addr=0, busy=0, done=0, err=0, state=IDLE, internal counters 0.

## Timing
- Start accepted at edge T0: FETCH in cycle after T0; seq_out shows first pattern 2 edges after T0.
- Non-last step with hold H: pattern visible for H+3 cycles (H+1 in HOLD, plus FETCH and APPLY of the next step).
- Last step with hold H: H+1 HOLD cycles, then 1 FINISH cycle with done=1; busy falls on the following edge.
- Total busy cycles for N steps with holds Hi: sum(Hi+3) + 1.
- A start arriving in the same cycle busy falls (state IDLE) is accepted; a start during FINISH is dropped.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
- Single step: mem[0x0A]=16'h8355 (last, hold 3, pattern 55); start with addr 0x0A -> seq_out=0x55 from edge T0+2; done pulses at cycle T0+7; busy high for 7 cycles; err=0.
- Three steps at 0x20..0x22 with holds 0,1,2, patterns 11/22/33, last on 0x22 -> seq_out holds 11 for 3, 22 for 4, 33 for 3 cycles; cur_addr steps 20,21,22; one done pulse.
- Wrap: entries at 0xFF (hold 0, not last) and 0x00 (last); start at 0xFF -> cur_addr 0xFF then 0x00; normal done; err=0.
- No last flag anywhere, start at 0x00 -> exactly 256 APPLYs, err=1, done pulse; next start clears err.
- abort during HOLD of step 2 -> next edge seq_out=IDLE_PATTERN, busy=0, no done. start+abort in the same IDLE cycle -> stays IDLE.
- Assert rst mid-HOLD -> all outputs immediately at reset values; after release, a start replays correctly. Write to the next index during HOLD -> new entry is played.

Source files
------------

// File: rtl/logic_seq_player.sv
// Step-table sequence player: walks a 256x16 table from a latched start index,
// driving each entry's pattern for its hold count until a "last" entry.
module logic_seq_player #(
    parameter logic [7:0] IDLE_PATTERN = 8'h00,
    parameter int         MAX_STEPS    = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  logic_start_addr,
    input  logic        abort,
    input  logic [7:0]  s_addr,
    input  logic        s_wren,
    input  logic [15:0] s_data,
    output logic [7:0]  seq_out,
    output logic [7:0]  cur_addr,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int CNT_W = $clog2(MAX_STEPS + 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_APPLY  = 3'd2,
        ST_HOLD   = 3'd3,
        ST_FINISH = 3'd4
    } state_t;

    state_t             state_r;
    logic [15:0]        mem_r [0:255];
    logic [15:0]        rd_data_r;
    logic [7:0]         ptr_r;
    logic [6:0]         hold_cnt_r;
    logic               last_r;
    logic [CNT_W-1:0]   step_cnt_r;
    logic [7:0]         seq_out_r;
    logic [7:0]         cur_addr_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;

    // Step table: write port for firmware, read of the current pointer every cycle.
    // A same-edge write/read to one index returns the old contents.
    always_ff @(posedge clk) begin
        if (s_wren) begin
            mem_r[s_addr] <= s_data;
        end
        rd_data_r <= mem_r[ptr_r];
    end

    // Sequencer FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 8'h00;
            hold_cnt_r <= 7'd0;
            last_r     <= 1'b0;
            step_cnt_r <= '0;
            seq_out_r  <= IDLE_PATTERN;
            cur_addr_r <= 8'h00;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort) begin
                // Abort wins over everything; err is deliberately left as is.
                state_r   <= ST_IDLE;
                busy_r    <= 1'b0;
                seq_out_r <= IDLE_PATTERN;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (start) begin
                            ptr_r      <= logic_start_addr;
                            step_cnt_r <= '0;
                            err_r      <= 1'b0;
                            busy_r     <= 1'b1;
                            state_r    <= ST_FETCH;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_FETCH: begin
                        cur_addr_r <= ptr_r;
                        state_r    <= ST_APPLY;
                    end
                    ST_APPLY: begin
                        seq_out_r  <= rd_data_r[7:0];
                        hold_cnt_r <= rd_data_r[14:8];
                        last_r     <= rd_data_r[15];
                        step_cnt_r <= step_cnt_r + CNT_W'(1);
                        state_r    <= ST_HOLD;
                    end
                    ST_HOLD: begin
                        if (hold_cnt_r != 7'd0) begin
                            hold_cnt_r <= hold_cnt_r - 7'd1;
                        end else if (last_r) begin
                            done_r  <= 1'b1;
                            state_r <= ST_FINISH;
                        end else if (step_cnt_r == CNT_W'(MAX_STEPS)) begin
                            err_r   <= 1'b1;
                            done_r  <= 1'b1;
                            state_r <= ST_FINISH;
                        end else begin
                            ptr_r   <= ptr_r + 8'd1;
                            state_r <= ST_FETCH;
                        end
                    end
                    ST_FINISH: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign seq_out  = seq_out_r;
    assign cur_addr = cur_addr_r;
    assign busy     = busy_r;
    assign done     = done_r;
    assign err      = err_r;

endmodule

// File: tb/tb_logic_seq_player.sv
// Directed bench for logic_seq_player: per-cycle vector table plus hand-written
// sequences for wrap, abort, reset, live table writes and step-limit error.
module tb_logic_seq_player;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  logic_start_addr;
    logic        abort;
    logic [7:0]  s_addr;
    logic        s_wren;
    logic [15:0] s_data;
    logic [7:0]  seq_out;
    logic [7:0]  cur_addr;
    logic        busy;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       start;
        logic       abort;
        logic [7:0] addr;
        logic [7:0] seq;
        logic [7:0] cur;
        logic       busy;
        logic       done;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    logic_seq_player dut (
        .clk(clk), .rst(rst), .start(start), .logic_start_addr(logic_start_addr),
        .abort(abort), .s_addr(s_addr), .s_wren(s_wren), .s_data(s_data),
        .seq_out(seq_out), .cur_addr(cur_addr), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [7:0] e_seq, input logic [7:0] e_cur,
                           input logic e_busy, input logic e_done, input logic e_err);
        chk({name, ".seq_out"},  int'(seq_out),  int'(e_seq));
        chk({name, ".cur_addr"}, int'(cur_addr), int'(e_cur));
        chk({name, ".busy"},     int'(busy),     int'(e_busy));
        chk({name, ".done"},     int'(done),     int'(e_done));
        chk({name, ".err"},      int'(err),      int'(e_err));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        s_addr = a;
        s_data = d;
        s_wren = 1'b1;
        tick();
        s_wren = 1'b0;
    endtask

    function automatic vec_t mk(input logic st, input logic ab, input logic [7:0] ad,
                                input logic [7:0] sq, input logic [7:0] cu,
                                input logic bu, input logic dn, input logic er);
        vec_t v;
        v.start = st; v.abort = ab; v.addr = ad;
        v.seq = sq; v.cur = cu; v.busy = bu; v.done = dn; v.err = er;
        return v;
    endfunction

    initial begin
        int  cnt;
        bit  seen_done;

        rst = 1'b1; start = 1'b0; abort = 1'b0; logic_start_addr = 8'h00;
        s_addr = 8'h00; s_wren = 1'b0; s_data = 16'h0000;
        tick();
        tick();
        chk_all("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        tick();

        wr(8'h0A, 16'h8355);
        wr(8'h20, 16'h0011);
        wr(8'h21, 16'h0122);
        wr(8'h22, 16'h8233);

        // single step at 0x0A: hold 3, last
        vecs.push_back(mk(1'b1, 1'b0, 8'h0A, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h00, 8'h0A, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h55, 8'h0A, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h55, 8'h0A, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h55, 8'h0A, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h55, 8'h0A, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h55, 8'h0A, 1'b1, 1'b1, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h55, 8'h0A, 1'b0, 1'b0, 1'b0));
        // three steps 0x20..0x22, started right after busy fell
        vecs.push_back(mk(1'b1, 1'b0, 8'h20, 8'h55, 8'h0A, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h55, 8'h20, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h11, 8'h20, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h11, 8'h20, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h11, 8'h21, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h22, 8'h21, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h22, 8'h21, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h22, 8'h21, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h22, 8'h22, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h33, 8'h22, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h33, 8'h22, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 8'h0A, 8'h33, 8'h22, 1'b1, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h33, 8'h22, 1'b1, 1'b1, 1'b0));
        // start sampled during FINISH is dropped
        vecs.push_back(mk(1'b1, 1'b0, 8'h0A, 8'h33, 8'h22, 1'b0, 1'b0, 1'b0));
        vecs.push_back(mk(1'b0, 1'b0, 8'h00, 8'h33, 8'h22, 1'b0, 1'b0, 1'b0));

        foreach (vecs[i]) begin
            start = vecs[i].start;
            abort = vecs[i].abort;
            logic_start_addr = vecs[i].addr;
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].seq, vecs[i].cur,
                    vecs[i].busy, vecs[i].done, vecs[i].err);
        end
        start = 1'b0;

        // wrap 0xFF -> 0x00
        wr(8'hFF, 16'h00AA);
        wr(8'h00, 16'h80BB);
        start = 1'b1; logic_start_addr = 8'hFF; tick(); start = 1'b0;
        chk_all("wrap0", 8'h33, 8'h22, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("wrap1", 8'h33, 8'hFF, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("wrap2", 8'hAA, 8'hFF, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("wrap3", 8'hAA, 8'hFF, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("wrap4", 8'hAA, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("wrap5", 8'hBB, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("wrap6", 8'hBB, 8'h00, 1'b1, 1'b1, 1'b0);
        tick(); chk_all("wrap7", 8'hBB, 8'h00, 1'b0, 1'b0, 1'b0);

        // abort during HOLD of step 2 (0x21)
        start = 1'b1; logic_start_addr = 8'h20; tick(); start = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk_all("abort_pre", 8'h22, 8'h21, 1'b1, 1'b0, 1'b0);
        abort = 1'b1; tick(); abort = 1'b0;
        chk_all("abort0", 8'h00, 8'h21, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk_all($sformatf("abort_after%0d", k), 8'h00, 8'h21, 1'b0, 1'b0, 1'b0);
        end

        // start and abort together in IDLE
        start = 1'b1; abort = 1'b1; logic_start_addr = 8'h0A; tick();
        start = 1'b0; abort = 1'b0;
        chk_all("start_abort0", 8'h00, 8'h21, 1'b0, 1'b0, 1'b0);
        tick(); chk_all("start_abort1", 8'h00, 8'h21, 1'b0, 1'b0, 1'b0);

        // rewrite the next entry while the current step is held
        start = 1'b1; logic_start_addr = 8'h20; tick(); start = 1'b0;
        tick(); tick();
        chk_all("livewr_hold", 8'h11, 8'h20, 1'b1, 1'b0, 1'b0);
        wr(8'h21, 16'h8077);
        chk_all("livewr_fetch", 8'h11, 8'h20, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("livewr_apply", 8'h11, 8'h21, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("livewr_new", 8'h77, 8'h21, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("livewr_done", 8'h77, 8'h21, 1'b1, 1'b1, 1'b0);
        tick(); chk_all("livewr_idle", 8'h77, 8'h21, 1'b0, 1'b0, 1'b0);

        // asynchronous reset mid-HOLD, then replay
        start = 1'b1; logic_start_addr = 8'h0A; tick(); start = 1'b0;
        tick(); tick();
        chk_all("rst_pre", 8'h55, 8'h0A, 1'b1, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1 chk_all("rst_async", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        tick(); rst = 1'b0;
        tick(); chk_all("rst_release", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        start = 1'b1; logic_start_addr = 8'h0A; tick(); start = 1'b0;
        chk_all("replay0", 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("replay1", 8'h00, 8'h0A, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("replay2", 8'h55, 8'h0A, 1'b1, 1'b0, 1'b0);
        tick(); tick(); tick();
        chk_all("replay5", 8'h55, 8'h0A, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("replay6", 8'h55, 8'h0A, 1'b1, 1'b1, 1'b0);
        tick(); chk_all("replay7", 8'h55, 8'h0A, 1'b0, 1'b0, 1'b0);

        // no last flag anywhere: forced stop after 256 steps with err
        for (int k = 0; k < 256; k++) wr(8'(k), {1'b0, 7'd0, 8'(k)});
        start = 1'b1; logic_start_addr = 8'h00; tick(); start = 1'b0;
        cnt = 0;
        seen_done = 1'b0;
        for (int k = 0; k < 2000 && !seen_done; k++) begin
            if (busy) cnt++;
            if (done) seen_done = 1'b1;
            else tick();
        end
        chk("maxsteps.done_seen", int'(seen_done), 1);
        chk("maxsteps.busy_cycles", cnt, 256 * 3 + 1);
        chk("maxsteps.err", int'(err), 1);
        chk("maxsteps.seq_out", int'(seq_out), 8'hFF);
        tick(); chk_all("maxsteps_idle", 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1);
        wr(8'h05, 16'h8000);
        chk("err_sticky", int'(err), 1);
        start = 1'b1; logic_start_addr = 8'h05; tick(); start = 1'b0;
        chk_all("errclr0", 8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        chk_all("errclr2", 8'h00, 8'h05, 1'b1, 1'b0, 1'b0);
        tick(); chk_all("errclr3", 8'h00, 8'h05, 1'b1, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
